btn_conditioner: RTL

Input-conditioning stage directly upstream of the per-player press latches in the tug-of-war datapath. It takes asynchronous, bouncy player pushbuttons and makes them usable by the latch "in" inputs. Per button it synchronises, debounces with a 4-state FSM and emits one clean single-cycle press pulse per physical press. It also provides a debounced level output for the game controller.

---
 rtl/btn_conditioner_pkg.sv | 14 +
 rtl/btn_conditioner_if.sv | 23 ++
 rtl/btn_conditioner_debounce_ch.sv | 105 ++++++++++
 rtl/btn_conditioner.sv | 28 ++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the tug-of-war input stage: the debounce FSM encoding
// and the default debounce length.
package tow_pkg;

  localparam int DEBOUNCE_CYC_DEF = 16;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_t;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button-conditioner bundle: raw levels and enable in, pulses and levels out,
// plus the per-channel FSM state for observation.
interface btn_conditioner_if #(
  parameter int NUM_BTN = 2
);
  // No handshake: press_pulse is a one-cycle strobe the consumer must take on
  // the cycle it is high; btn_level is a plain level. en gates pulses only.
  logic [NUM_BTN-1:0]      btn_raw;
  logic                    en;
  logic [NUM_BTN-1:0]      press_pulse;
  logic [NUM_BTN-1:0]      btn_level;
  logic [NUM_BTN-1:0][1:0] dbg_state;

  modport master (
    output btn_raw, en,
    input  press_pulse, btn_level, dbg_state
  );

  modport slave (
    input  btn_raw, en,
    output press_pulse, btn_level, dbg_state
  );
endinterface

// File: rtl/btn_conditioner_debounce_ch.sv
// One button channel: two-flop synchroniser, stability counter and
// press/release FSM producing a single-cycle press pulse and a debounced level.
module btn_debounce_ch
  import tow_pkg::*;
#(
  parameter  int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  localparam int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_raw,
  input  logic       i_en,
  output logic       o_pulse,
  output logic       o_level,
  output logic [1:0] o_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_level;

  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pulse_nxt;
  logic             w_level_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
    end
  end

  // The pulse is decided on the accepting edge only, so a later rise of en
  // can never produce a deferred pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (r_sync2) begin
          w_state_nxt = PRESS_PEND;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_PEND: begin
        if (!r_sync2) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_pulse_nxt = i_en;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!r_sync2) begin
          w_state_nxt = RELEASE_PEND;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_PEND: begin
        if (r_sync2) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
    w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_PEND);
  end

  assign o_pulse = r_pulse;
  assign o_level = r_level;
  assign o_state = r_state;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions NUM_BTN asynchronous player buttons into clean press pulses and
// debounced levels; channels are independent and share only the enable.
module btn_conditioner
  import tow_pkg::*;
#(
  parameter int NUM_BTN      = 2,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input logic              clk,
  input logic              rst,
  btn_conditioner_if.slave bus
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_btn_raw (bus.btn_raw[g]),
      .i_en      (bus.en),
      .o_pulse   (bus.press_pulse[g]),
      .o_level   (bus.btn_level[g]),
      .o_state   (bus.dbg_state[g])
    );
  end

endmodule
